// File: rtl/qsys_timer_sched.sv
// Avalon-MM sequencer that runs the interval timer with no CPU involvement:
// it programs the period, services timeouts and takes counter snapshots.
// Optional one-shot mode is compiled in with QSYS_TIMER_SCHED_ONESHOT_EN.
module qsys_timer_sched #(
  parameter logic [3:0] CTRL_RUN  = 4'h7,
  parameter logic [3:0] CTRL_STOP = 4'h8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] cfg_period,
  input  logic        cfg_start,
  input  logic        cfg_stop,
`ifdef QSYS_TIMER_SCHED_ONESHOT_EN
  input  logic        cfg_oneshot,
`endif
  output logic        busy,
  output logic        tick_pulse,
  output logic [31:0] tick_count,
  input  logic        snap_req,
  output logic        snap_valid,
  output logic [31:0] snap_value,
  output logic [2:0]  tmr_address,
  output logic        tmr_chipselect,
  output logic        tmr_write_n,
  output logic [15:0] tmr_writedata,
  input  logic [15:0] tmr_readdata,
  input  logic        tmr_irq
);

  localparam logic [2:0] A_STATUS   = 3'd0;
  localparam logic [2:0] A_CONTROL  = 3'd1;
  localparam logic [2:0] A_PERIOD_L = 3'd2;
  localparam logic [2:0] A_PERIOD_H = 3'd3;
  localparam logic [2:0] A_SNAP_L   = 3'd4;
  localparam logic [2:0] A_SNAP_H   = 3'd5;
  localparam logic [3:0] CTRL_ONESHOT = 4'h5;

  typedef enum logic [3:0] {
    S_IDLE, S_WR_PL, S_WR_PH, S_WR_CLR0, S_WR_RUN, S_RUN, S_SVC,
    S_SN_WR, S_SN_RL, S_SN_RH, S_SN_DONE, S_WR_STOP
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] period_q;
  logic [15:0] snap_lo_q;
  logic [31:0] snap_q;
  logic        stop_pend, snap_pend, oneshot_q;
  logic        start_ok;

  assign start_ok = (state == S_IDLE) && cfg_start && (cfg_period != 32'h0);
  assign busy     = (state != S_IDLE);

`ifdef QSYS_TIMER_SCHED_ONESHOT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)      oneshot_q <= 1'b0;
    else if (start_ok) oneshot_q <= cfg_oneshot;
  end
`else
  assign oneshot_q = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:    if (start_ok) state_nxt = S_WR_PL;
      S_WR_PL:   state_nxt = S_WR_PH;
      S_WR_PH:   state_nxt = S_WR_CLR0;
      S_WR_CLR0: state_nxt = S_WR_RUN;
      S_WR_RUN:  state_nxt = S_RUN;
      S_RUN: begin
        if (stop_pend || cfg_stop)      state_nxt = S_WR_STOP;
        else if (tmr_irq)               state_nxt = S_SVC;
        else if (snap_pend || snap_req) state_nxt = S_SN_WR;
      end
      S_SVC:     state_nxt = oneshot_q ? S_IDLE : S_RUN;
      S_SN_WR:   state_nxt = S_SN_RL;
      S_SN_RL:   state_nxt = S_SN_RH;
      S_SN_RH:   state_nxt = S_SN_DONE;
      S_SN_DONE: state_nxt = S_RUN;
      S_WR_STOP: state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // Requests that cannot be acted on immediately are held until RUN; going idle drops them.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stop_pend <= 1'b0;
      snap_pend <= 1'b0;
    end else begin
      if (state_nxt == S_IDLE)
        stop_pend <= 1'b0;
      else if (cfg_stop && state != S_IDLE && state != S_RUN)
        stop_pend <= 1'b1;

      if (state_nxt == S_IDLE || state_nxt == S_SN_WR)
        snap_pend <= 1'b0;
      else if (snap_req && state != S_IDLE)
        snap_pend <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      period_q   <= 32'h0;
      tick_count <= 32'h0;
      snap_lo_q  <= 16'h0;
      snap_q     <= 32'h0;
    end else begin
      if (start_ok) begin
        period_q   <= cfg_period;
        tick_count <= 32'h0;
      end else if (state == S_SVC) begin
        tick_count <= tick_count + 32'd1;
      end
      if (state == S_SN_RH)   snap_lo_q <= tmr_readdata;
      if (state == S_SN_DONE) snap_q    <= {tmr_readdata, snap_lo_q};
    end
  end

  // The high half arrives in SN_DONE, so it is bypassed to keep snap_value valid with snap_valid.
  assign snap_value = (state == S_SN_DONE) ? {tmr_readdata, snap_lo_q} : snap_q;

  always_comb begin
    // NOTE: every output gets a default first, so no path through the case infers a latch.
    tmr_chipselect = 1'b0;
    tmr_write_n    = 1'b1;
    tmr_address    = A_STATUS;
    tmr_writedata  = 16'h0;
    tick_pulse     = 1'b0;
    snap_valid     = 1'b0;
    unique case (state)
      S_WR_PL: begin
        tmr_chipselect = 1'b1; tmr_write_n = 1'b0;
        tmr_address = A_PERIOD_L; tmr_writedata = period_q[15:0];
      end
      S_WR_PH: begin
        tmr_chipselect = 1'b1; tmr_write_n = 1'b0;
        tmr_address = A_PERIOD_H; tmr_writedata = period_q[31:16];
      end
      S_WR_CLR0: begin
        tmr_chipselect = 1'b1; tmr_write_n = 1'b0; tmr_address = A_STATUS;
      end
      S_WR_RUN: begin
        tmr_chipselect = 1'b1; tmr_write_n = 1'b0; tmr_address = A_CONTROL;
        tmr_writedata = {12'h0, oneshot_q ? CTRL_ONESHOT : CTRL_RUN};
      end
      S_SVC: begin
        tmr_chipselect = 1'b1; tmr_write_n = 1'b0; tmr_address = A_STATUS;
        tick_pulse = 1'b1;
      end
      S_SN_WR: begin
        tmr_chipselect = 1'b1; tmr_write_n = 1'b0; tmr_address = A_SNAP_L;
      end
      S_SN_RL: begin
        tmr_chipselect = 1'b1; tmr_address = A_SNAP_L;
      end
      S_SN_RH: begin
        tmr_chipselect = 1'b1; tmr_address = A_SNAP_H;
      end
      S_SN_DONE: snap_valid = 1'b1;
      S_WR_STOP: begin
        tmr_chipselect = 1'b1; tmr_write_n = 1'b0; tmr_address = A_CONTROL;
        tmr_writedata = {12'h0, CTRL_STOP};
      end
      default: ;
    endcase
  end

endmodule
